seq_controller: RTL
===================

# seq_controller

Parametrised datapath sequencer, successor to the fixed four-state start/overflow controller. On `start` it latches an operating mode and a step count, then drives the datapath through one LOAD cycle, a programmable number of EXEC cycles and one FINISH (writeback) cycle. It asserts datapath selects and flags as Moore outputs and traps datapath overflow in a sticky error state. It also adds abort, explicit error clear and run-length control.

## Interface
- `SEL_W`, 3: datapath select width; must be ≥ 3.
- `FLAG_W`, 3: datapath flag width; must be ≥ 3; bits above 2 are always 0.
- `MAX_STEPS`, 8: maximum EXEC cycles per run, ≥ 1.
- `CNT_W`: localparam, `$clog2(MAX_STEPS+1)`.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `abort`  in  1  terminate the run; sampled in LOAD/EXEC/FINISH.
- `clear_err`  in  1  leave ERR; sampled only in ERR.
- `ovf`  in  1  datapath overflow; sampled in LOAD/EXEC.
- `mode`  in  2  operation select; latched on the accepted start.
- `step_count`  in  CNT_W  EXEC cycle count; latched on the accepted start.
- `sel`  out  SEL_W  datapath mux select.
- `flags`  out  FLAG_W  datapath control flags.
- `step_idx`  out  CNT_W  current EXEC index, 0-based.
- `busy`  out  1  high in LOAD, EXEC and FINISH.
- `done`  out  1  high for exactly the single FINISH cycle.
- `error`  out  1  high throughout ERR.

## Operation
- States: IDLE, LOAD, EXEC, FINISH, ERR.
- All outputs are Moore outputs, decoded from the state and latched registers only.
- IDLE:
  - `sel`=0, `flags`=0.
  - `start`=1 → LOAD.
  - On that edge: latch `mode`→`mode_l`; latch the clamped `step_count`→`n_l` (0→1, >MAX_STEPS→MAX_STEPS); clear `step_idx`.
- LOAD:
  - `sel`=1, `flags`=0.
  - `ovf` → ERR, else → EXEC.
- EXEC:
  - `sel` = 2 + `mode_l` (2..5).
  - `flags[0]` = (`step_idx` == `n_l`-1); `flags[1]` = `mode_l[0]`; `flags[2]`=0.
  - `ovf` → ERR.
  - Else if last step → FINISH.
  - Else `step_idx`++ and stay.
- FINISH:
  - `sel` = all-ones (7 at default width); `flags[2]`=1; `flags[1]`=`mode_l[0]`; `done`=1.
  - Always → IDLE; `ovf` is ignored.
- ERR:
  - `sel`=0, `flags`=0, `error`=1, `busy`=0.
  - `clear_err` → IDLE. `start` is ignored, including when it arrives in the same cycle as `clear_err`.
- Priority within a busy state: `abort` > `ovf` > normal transition. `abort` → IDLE with no `done` and no `error`.
- `start` is ignored while busy. `mode`/`step_count` changes during a run have no effect.
- `step_idx` holds its last value in FINISH and ERR and clears on the next accepted start.

## Timing
- Reset values (asserted asynchronously):
  - State IDLE.
  - `step_idx`, `mode_l` and `n_l` all 0.
  - Outputs: `sel`=0, `flags`=0, `busy`=0, `done`=0, `error`=0.
- Reset mid-run or in ERR: immediate return to IDLE; the error is lost.
- Run with `start` sampled at edge k:
  - LOAD in cycle k+1.
  - EXEC in cycles k+2 … k+N+1.
  - FINISH/`done` in cycle k+N+2.
  - IDLE in cycle k+N+3.
- Start-to-done latency is N+2 cycles; `busy` is high for N+2 cycles.
- The earliest next start is sampled at the first IDLE edge, so back-to-back runs have a one-cycle IDLE gap.
- `ovf` sampled at the end of a LOAD/EXEC cycle: `error` rises the next cycle; `done` is never asserted for that run.
- `clear_err` sampled at edge j: `error`=0 from cycle j+1.

## Structure
- Package `seq_ctrl_pkg` holds:
  - The state enum.
  - Select constants: SEL_IDLE=0, SEL_LOAD=1, SEL_EXEC0=2, SEL_WB=all-ones.
  - Flag bit indices: FLG_LAST=0, FLG_MODE=1, FLG_WB=2.
- Sub-module `seq_step_counter` provides load-clear, increment, terminal-count compare against `n_l`, and clamping of `step_count`.
- The top level contains the FSM register, next-state logic and output decode.

## Test plan
1. Nominal run, defaults, `step_count`=3, `mode`=2, one-cycle `start`:
   - LOAD: `sel`=1.
   - EXEC ×3: `sel`=4, `step_idx` 0,1,2; `flags[0]` high only at idx 2.
   - FINISH: `sel`=7, `flags`=3'b100.
   - `done` 5 cycles after the start edge; `busy` high 5 cycles.
2. `ovf` at `step_idx`=1, `mode`=1:
   - ERR next cycle, `error`=1, `done` never high.
   - `start` held 4 cycles → no effect.
   - `clear_err`+`start` same cycle → IDLE, `error`=0, no run.
3. `abort` and `ovf` in the same EXEC cycle → IDLE next cycle, `error`=0, `done`=0. `ovf` in LOAD → ERR with no EXEC cycle.
4. Clamping:
   - `step_count`=0 → one EXEC cycle (`flags[0]` high), `done` 3 cycles after start.
   - `step_count`=15 (CNT_W=4, MAX_STEPS=8) → 8 EXEC cycles.
5. Latched inputs and retriggering:
   - Change `mode` and `step_count` mid-EXEC → `sel` and run length unchanged.
   - `start` in FINISH → ignored; the next run starts only when `start` is sampled in IDLE.
6. Drop `reset` to 0 asynchronously mid-EXEC and in ERR → all outputs 0 before the next clock edge. Release → IDLE, and a fresh run completes normally.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the datapath sequencer.
package seq_ctrl_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXEC,
    ST_FINISH,
    ST_ERR
  } state_t;

  // Datapath select codes; SEL_WB is truncated to the select width at use.
  localparam int unsigned SEL_IDLE  = 0;
  localparam int unsigned SEL_LOAD  = 1;
  localparam int unsigned SEL_EXEC0 = 2;
  localparam logic [31:0] SEL_WB    = '1;

  // Flag bit positions.
  localparam int unsigned FLG_LAST = 0;
  localparam int unsigned FLG_MODE = 1;
  localparam int unsigned FLG_WB   = 2;

endpackage

// File: rtl/seq_step_counter.sv
// EXEC step counter: clamps and latches the run length, tracks the step index.
module seq_step_counter #(
  parameter int unsigned MAX_STEPS = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  input  logic [CNT_W-1:0] step_count,
  output logic [CNT_W-1:0] step_idx,
  output logic [CNT_W-1:0] n_l,
  output logic             last_c,
  output logic             last_nxt_c
);

  logic [CNT_W-1:0] n_clamp_c;
  logic [CNT_W-1:0] idx_nxt_c;
  logic [CNT_W-1:0] n_nxt_c;

  // Clamp request to 1..MAX_STEPS and form next index / length.
  always_comb begin
    n_clamp_c = step_count;
    if (step_count == '0) begin
      n_clamp_c = CNT_W'(1);
    end else if (step_count > CNT_W'(MAX_STEPS)) begin
      n_clamp_c = CNT_W'(MAX_STEPS);
    end
    idx_nxt_c = step_idx;
    if (load) begin
      idx_nxt_c = '0;
    end else if (inc) begin
      idx_nxt_c = step_idx + CNT_W'(1);
    end
    n_nxt_c    = load ? n_clamp_c : n_l;
    last_c     = (step_idx == (n_l - CNT_W'(1)));
    last_nxt_c = (idx_nxt_c == (n_nxt_c - CNT_W'(1)));
  end

  // Index and run-length registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_idx <= '0;
      n_l      <= '0;
    end else begin
      step_idx <= idx_nxt_c;
      n_l      <= n_nxt_c;
    end
  end

endmodule

// File: rtl/seq_controller.sv
// Datapath sequencer: IDLE -> LOAD -> EXEC x N -> FINISH, with sticky overflow trap.
module seq_controller
  import seq_ctrl_pkg::*;
#(
  parameter  int unsigned SEL_W     = 3,
  parameter  int unsigned FLAG_W    = 3,
  parameter  int unsigned MAX_STEPS = 8,
  localparam int unsigned CNT_W     = $clog2(MAX_STEPS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              clear_err,
  input  logic              ovf,
  input  logic [MODE_W-1:0] mode,
  input  logic [CNT_W-1:0]  step_count,
  output logic [SEL_W-1:0]  sel,
  output logic [FLAG_W-1:0] flags,
  output logic [CNT_W-1:0]  step_idx,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t            state_q;
  state_t            state_nxt_c;
  logic [MODE_W-1:0] mode_l;
  logic [MODE_W-1:0] mode_nxt_c;
  logic              load_c;
  logic              inc_c;
  logic              last_c;
  logic              last_nxt_c;
  logic [CNT_W-1:0]  n_l;
  logic [SEL_W-1:0]  sel_nxt_c;
  logic [FLAG_W-1:0] flags_nxt_c;
  logic              busy_nxt_c;
  logic              done_nxt_c;
  logic              error_nxt_c;

  seq_step_counter #(
    .MAX_STEPS (MAX_STEPS),
    .CNT_W     (CNT_W)
  ) u_step_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (load_c),
    .inc        (inc_c),
    .step_count (step_count),
    .step_idx   (step_idx),
    .n_l        (n_l),
    .last_c     (last_c),
    .last_nxt_c (last_nxt_c)
  );

  // Next-state logic; abort beats ovf beats the normal transition.
  always_comb begin
    state_nxt_c = state_q;
    load_c      = 1'b0;
    inc_c       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_nxt_c = ST_LOAD;
          load_c      = 1'b1;
        end
      end
      ST_LOAD: begin
        if (abort)    state_nxt_c = ST_IDLE;
        else if (ovf) state_nxt_c = ST_ERR;
        else          state_nxt_c = ST_EXEC;
      end
      ST_EXEC: begin
        if (abort)       state_nxt_c = ST_IDLE;
        else if (ovf)    state_nxt_c = ST_ERR;
        else if (last_c) state_nxt_c = ST_FINISH;
        else             inc_c = 1'b1;
      end
      ST_FINISH: state_nxt_c = ST_IDLE;
      ST_ERR: begin
        if (clear_err) state_nxt_c = ST_IDLE;
      end
      default: state_nxt_c = ST_IDLE;
    endcase
  end

  // Moore output decode from the next state so the outputs can be registered.
  always_comb begin
    mode_nxt_c  = load_c ? mode : mode_l;
    sel_nxt_c   = SEL_W'(SEL_IDLE);
    flags_nxt_c = '0;
    busy_nxt_c  = 1'b0;
    done_nxt_c  = 1'b0;
    error_nxt_c = 1'b0;
    case (state_nxt_c)
      ST_LOAD: begin
        sel_nxt_c  = SEL_W'(SEL_LOAD);
        busy_nxt_c = 1'b1;
      end
      ST_EXEC: begin
        sel_nxt_c             = SEL_W'(SEL_EXEC0) + SEL_W'(mode_nxt_c);
        flags_nxt_c[FLG_LAST] = last_nxt_c;
        flags_nxt_c[FLG_MODE] = mode_nxt_c[0];
        busy_nxt_c            = 1'b1;
      end
      ST_FINISH: begin
        sel_nxt_c             = SEL_W'(SEL_WB);
        flags_nxt_c[FLG_WB]   = 1'b1;
        flags_nxt_c[FLG_MODE] = mode_nxt_c[0];
        busy_nxt_c            = 1'b1;
        done_nxt_c            = 1'b1;
      end
      ST_ERR: error_nxt_c = 1'b1;
      default: ;
    endcase
  end

  // State, latched mode and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mode_l  <= '0;
      sel     <= '0;
      flags   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state_q <= state_nxt_c;
      mode_l  <= mode_nxt_c;
      sel     <= sel_nxt_c;
      flags   <= flags_nxt_c;
      busy    <= busy_nxt_c;
      done    <= done_nxt_c;
      error   <= error_nxt_c;
    end
  end

endmodule
